// File: rtl/coin_seq_pkg.sv
// Shared types and helpers for the coin/start sequencer and its millisecond timer.
package coin_seq_pkg;

   localparam int unsigned MS_W = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COIN  = 3'd1,
      GAP   = 3'd2,
      START = 3'd3,
      HOLD  = 3'd4
   } seq_state_t;

   // Clock cycles per millisecond, never below one so the prescaler stays well formed.
   function automatic int unsigned calc_tick_div(input int unsigned clk_hz);
      int unsigned div;
      div = clk_hz / 1000;
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: prescaler producing a 1 ms tick plus a millisecond counter, both
// cleared synchronously by clr_i.
module ms_timer
   import coin_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = 40000
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   output logic            tick_o,
   output logic [MS_W-1:0] ms_o
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [MS_W-1:0]  ms_q, ms_d;

   assign tick_o = (pre_q == PRE_MAX);
   assign ms_o   = ms_q;

   always_comb begin
      pre_d = pre_q;
      ms_d  = ms_q;
      if (clr_i) begin
         pre_d = '0;
         ms_d  = '0;
      end else if (tick_o) begin
         pre_d = '0;
         ms_d  = ms_q + 1'b1;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end

endmodule

// File: rtl/coin_start_sequencer.sv
// One-button start sequencer: turns a start request into coin pulse, gap, start pulse.
// Optional coin credit counter enabled by defining COIN_COUNT_EN.
module coin_start_sequencer
   import coin_seq_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 40000000,
   parameter int unsigned COIN_MS  = 100,
   parameter int unsigned GAP_MS   = 200,
   parameter int unsigned START_MS = 100
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        req_start1,
   input  logic        req_start2,
   input  logic        coin_in,
   input  logic        start1_in,
   input  logic        start2_in,
   output logic        coin1,
   output logic        start1,
   output logic        start2,
`ifdef COIN_COUNT_EN
   output logic [15:0] credits_out,
`endif
   output logic        busy
);

   localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ);
   localparam logic [MS_W-1:0] COIN_LAST  = MS_W'(COIN_MS - 1);
   localparam logic [MS_W-1:0] GAP_LAST   = MS_W'(GAP_MS - 1);
   localparam logic [MS_W-1:0] START_LAST = MS_W'(START_MS - 1);

   seq_state_t      state_q, state_d;
   logic            req1_q, req2_q;
   logic            sel_q, sel_d;
   logic            rise1, rise2;
   logic            tick;
   logic [MS_W-1:0] ms_cnt;
   logic [MS_W-1:0] ms_last;
   logic            phase_done;
   logic            timer_clr;

   assign rise1 = req_start1 & ~req1_q;
   assign rise2 = req_start2 & ~req2_q;

   always_comb begin
      ms_last = COIN_LAST;
      unique case (state_q)
         GAP:     ms_last = GAP_LAST;
         START:   ms_last = START_LAST;
         default: ms_last = COIN_LAST;
      endcase
   end

   assign phase_done = tick & (ms_cnt == ms_last);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      unique case (state_q)
         IDLE: begin
            if (rise1 | rise2) begin
               state_d = COIN;
               sel_d   = ~rise1;  // player 1 wins a simultaneous rise
            end
         end
         COIN:    if (phase_done) state_d = GAP;
         GAP:     if (phase_done) state_d = START;
         START:   if (phase_done) state_d = HOLD;
         HOLD:    if (!req_start1 && !req_start2) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Restart the timer on every state entry so each phase gets an exact cycle count.
   assign timer_clr = (state_d != state_q);

   ms_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_ms_timer (
      .clk_i (clk_sys),
      .rst_ni(reset_n),
      .clr_i (timer_clr),
      .tick_o(tick),
      .ms_o  (ms_cnt)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         req1_q  <= 1'b1;  // a request already held at release must not trigger
         req2_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         req1_q  <= req_start1;
         req2_q  <= req_start2;
      end
   end

   assign coin1  = (state_q == COIN) | coin_in;
   assign start1 = ((state_q == START) & ~sel_q) | start1_in;
   assign start2 = ((state_q == START) & sel_q) | start2_in;
   assign busy   = (state_q != IDLE);

`ifdef COIN_COUNT_EN
   logic        coin_in_q;
   logic [15:0] credits_q, credits_d;
   logic        credit_inc;

   assign credit_inc = ((state_q != COIN) & (state_d == COIN)) | (coin_in & ~coin_in_q);

   always_comb begin
      credits_d = credits_q;
      if (credit_inc && (credits_q != 16'hFFFF)) begin
         credits_d = credits_q + 16'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_in_q <= 1'b0;
         credits_q <= '0;
      end else begin
         coin_in_q <= coin_in;
         credits_q <= credits_d;
      end
   end

   assign credits_out = credits_q;
`endif

endmodule
